// File: rtl/rr_arb_2x1.sv
// Two-channel round-robin arbiter feeding a one-entry valid/ready output register.
// Optional per-channel grant counters are enabled with `define ARB_GRANT_CNT_EN.
module rr_arb_2x1 #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in0_data,
    output logic              in0_ready,
    input  logic              in1_valid,
    input  logic [DATA_W-1:0] in1_data,
    output logic              in1_ready,
    output logic              sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    input  logic              out_ready
`ifdef ARB_GRANT_CNT_EN
    ,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state;
    logic   last;
    logic   any_req;
    logic   accept;
    logic   grant;
    logic   transfer;

    // Nothing is accepted while reset is held, so ready never leaks out of reset.
    always_comb begin
        any_req  = in0_valid | in1_valid;
        accept   = reset_n & ((state == EMPTY) | out_ready);
        grant    = last;
        if (in0_valid && in1_valid) begin
            grant = ~last;
        end else if (in1_valid) begin
            grant = 1'b1;
        end else if (in0_valid) begin
            grant = 1'b0;
        end
        transfer  = accept & any_req;
        sel       = grant;
        in0_ready = transfer & ~grant;
        in1_ready = transfer & grant;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            last      <= 1'b1;
        end else if (transfer) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_data  <= grant ? in1_data : in0_data;
            out_src   <= grant;
            last      <= grant;
        end else if (state == FULL && out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
        end
    end

`ifdef ARB_GRANT_CNT_EN
    // Counters wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else if (transfer) begin
            if (grant) begin
                grant_cnt1 <= grant_cnt1 + 1'b1;
            end else begin
                grant_cnt0 <= grant_cnt0 + 1'b1;
            end
        end
    end
`else
    // Keeps CNT_W referenced in builds without counters.
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_rr_arb_2x1.sv
// Directed self-checking bench for rr_arb_2x1; the counter test is built only with ARB_GRANT_CNT_EN.
module tb_rr_arb_2x1;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in0_valid;
    logic [DATA_W-1:0] in0_data;
    logic              in0_ready;
    logic              in1_valid;
    logic [DATA_W-1:0] in1_data;
    logic              in1_ready;
    logic              sel;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_src;
    logic              out_ready;
`ifdef ARB_GRANT_CNT_EN
    logic [CNT_W-1:0]  grant_cnt0;
    logic [CNT_W-1:0]  grant_cnt1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arb_2x1 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
`ifdef ARB_GRANT_CNT_EN
        ,
        .grant_cnt0(grant_cnt0),
        .grant_cnt1(grant_cnt1)
`endif
    );

    task test_reset();
        reset_n = 1'b0; in0_valid = 1'b1; in1_valid = 1'b1;
        in0_data = 8'hA0; in1_data = 8'hB1; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b expected 0", out_valid); end
        checks++; if (in0_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in0_ready got %b expected 0", in0_ready); end
        checks++; if (in1_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in1_ready got %b expected 0", in1_ready); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_data got %h expected 00", out_data); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++; if (in0_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in0_ready got %b expected 1", in0_ready); end
        checks++; if (in1_ready !== 1'b0) begin errors++; $display("[TB] FAIL release_in1_ready got %b expected 0", in1_ready); end
        checks++; if (sel !== 1'b0) begin errors++; $display("[TB] FAIL release_sel got %b expected 0", sel); end
    endtask

    task test_alternate();
        logic       exp_src;
        logic [7:0] exp_data;
        for (int i = 0; i < 4; i++) begin
            exp_src  = (i % 2 == 1);
            exp_data = exp_src ? 8'hB1 : 8'hA0;
            checks++; if (sel !== exp_src) begin errors++; $display("[TB] FAIL alt_sel[%0d] got %b expected %b", i, sel, exp_src); end
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL alt_out_valid[%0d] got %b expected 1", i, out_valid); end
            checks++; if (out_src !== exp_src) begin errors++; $display("[TB] FAIL alt_out_src[%0d] got %b expected %b", i, out_src, exp_src); end
            checks++; if (out_data !== exp_data) begin errors++; $display("[TB] FAIL alt_out_data[%0d] got %h expected %h", i, out_data, exp_data); end
            @(negedge clk);
            #1;
        end
    endtask

    task test_single();
        in0_valid = 1'b0; in1_data = 8'h5C;
        #1;
        checks++; if (sel !== 1'b1) begin errors++; $display("[TB] FAIL single_sel got %b expected 1", sel); end
        checks++; if (in1_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_in1_ready got %b expected 1", in1_ready); end
        checks++; if (in0_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_in0_ready got %b expected 0", in0_ready); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_out_valid got %b expected 1", out_valid); end
        checks++; if (out_data !== 8'h5C) begin errors++; $display("[TB] FAIL single_out_data got %h expected 5c", out_data); end
        checks++; if (out_src !== 1'b1) begin errors++; $display("[TB] FAIL single_out_src got %b expected 1", out_src); end
        @(negedge clk);
        #1;
    endtask

    task test_stall();
        in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (in0_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in0_ready[%0d] got %b expected 0", i, in0_ready); end
            checks++; if (in1_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in1_ready[%0d] got %b expected 0", i, in1_ready); end
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_out_valid[%0d] got %b expected 1", i, out_valid); end
            checks++; if (out_data !== 8'h5C) begin errors++; $display("[TB] FAIL stall_out_data[%0d] got %h expected 5c", i, out_data); end
            checks++; if (out_src !== 1'b1) begin errors++; $display("[TB] FAIL stall_out_src[%0d] got %b expected 1", i, out_src); end
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in0_ready !== 1'b1) begin errors++; $display("[TB] FAIL unstall_in0_ready got %b expected 1", in0_ready); end
        checks++; if (sel !== 1'b0) begin errors++; $display("[TB] FAIL unstall_sel got %b expected 0", sel); end
        @(posedge clk);
        #1;
        checks++; if (out_data !== 8'hA0) begin errors++; $display("[TB] FAIL unstall_out_data got %h expected a0", out_data); end
        checks++; if (out_src !== 1'b0) begin errors++; $display("[TB] FAIL unstall_out_src got %b expected 0", out_src); end
        @(negedge clk);
        #1;
    endtask

    task test_drain();
        in0_valid = 1'b0; in1_valid = 1'b0;
        #1;
        checks++; if (sel !== 1'b0) begin errors++; $display("[TB] FAIL idle_sel got %b expected 0", sel); end
        checks++; if (in0_ready !== 1'b0) begin errors++; $display("[TB] FAIL idle_in0_ready got %b expected 0", in0_ready); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_out_valid got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'hA0) begin errors++; $display("[TB] FAIL drain_out_data got %h expected a0", out_data); end
        @(negedge clk);
        #1;
        checks++; if (sel !== 1'b0) begin errors++; $display("[TB] FAIL idle_hold_sel got %b expected 0", sel); end
    endtask

    task test_async_reset();
        in0_valid = 1'b1; in1_valid = 1'b1;
        #1;
        checks++; if (in1_ready !== 1'b1) begin errors++; $display("[TB] FAIL prio_in1_ready got %b expected 1", in1_ready); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL prio_out_valid got %b expected 1", out_valid); end
        checks++; if (out_data !== 8'h5C) begin errors++; $display("[TB] FAIL prio_out_data got %h expected 5c", out_data); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_out_valid got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("[TB] FAIL async_out_data got %h expected 00", out_data); end
        checks++; if (out_src !== 1'b0) begin errors++; $display("[TB] FAIL async_out_src got %b expected 0", out_src); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++; if (in0_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_in0_ready got %b expected 1", in0_ready); end
    endtask

`ifdef ARB_GRANT_CNT_EN
    task test_grant_cnt();
        in0_valid = 1'b1; in1_valid = 1'b0; out_ready = 1'b1;
        repeat (17) @(posedge clk);
        #1;
        checks++; if (grant_cnt0 !== 4'd1) begin errors++; $display("[TB] FAIL grant_cnt0 got %0d expected 1", grant_cnt0); end
        checks++; if (grant_cnt1 !== 4'd0) begin errors++; $display("[TB] FAIL grant_cnt1 got %0d expected 0", grant_cnt1); end
    endtask
`endif

    initial begin
        test_reset();
        test_alternate();
        test_single();
        test_stall();
        test_drain();
        test_async_reset();
`ifdef ARB_GRANT_CNT_EN
        test_grant_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end
endmodule
